bm_seq_div_str_arch: RTL and testbench

//  Sequential restoring divider, the inverse of the multiply/MAC micro benchmarks.

---
 rtl/bm_seq_div_str_arch.sv | 105 ++++++++++
 tb/tb_bm_seq_div_str_arch.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/bm_seq_div_str_arch.sv
// bm_seq_div_str_arch: sequential restoring divider, one quotient bit per clock
// BM_SEQ_DIV_SIGNED_EN selects two's complement operands with a one-cycle sign fix-up
module bm_seq_div_str_arch #(
   parameter int DIVIDEND_W = 36,
   parameter int DIVISOR_W  = 18,
   parameter int CNT_W      = 6
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic                  busy,
   output logic                  done,
   output logic                  div_by_zero,
   output logic [DIVIDEND_W-1:0] quotient,
   output logic [DIVISOR_W-1:0]  remainder
);
   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
   state_t state, state_nxt;
   logic [CNT_W-1:0]      cnt;
   logic [DIVIDEND_W-1:0] acc, acc_nxt, dvd_mag;
   logic [DIVISOR_W:0]    prem, prem_nxt;
   logic [DIVISOR_W+1:0]  shifted;
   logic [DIVISOR_W-1:0]  dvs, dvs_mag;
   logic accept, zero, last, ge;
`ifdef BM_SEQ_DIV_SIGNED_EN
   logic neg_q, neg_r;
   localparam state_t LAST_NXT = FIX;
   assign dvd_mag = dividend[DIVIDEND_W-1] ? -dividend : dividend;
   assign dvs_mag = divisor[DIVISOR_W-1] ? -divisor : divisor;
`else
   localparam state_t LAST_NXT = DONE;
   assign dvd_mag = dividend;
   assign dvs_mag = divisor;
`endif
   assign accept = start && (state == IDLE || state == DONE);
   assign zero = divisor == '0;
   assign last = state == RUN && cnt == CNT_W'(1);
   assign busy = state == RUN || state == FIX;
   assign done = state == DONE;
   assign shifted = {prem, acc[DIVIDEND_W-1]};
   assign ge = shifted >= (DIVISOR_W+2)'(dvs);
   assign prem_nxt = (DIVISOR_W+1)'(ge ? shifted - (DIVISOR_W+2)'(dvs) : shifted);
   assign acc_nxt = {acc[DIVIDEND_W-2:0], ge};

   always_comb begin
      state_nxt = accept ? (zero ? DONE : RUN) :
                  last ? LAST_NXT :
                  state == FIX ? DONE :
                  state == DONE ? IDLE : state;
   end

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else state <= state_nxt;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt <= '0;
         acc <= '0;
         prem <= '0;
         dvs <= '0;
         div_by_zero <= 1'b0;
         quotient <= '0;
         remainder <= '0;
`ifdef BM_SEQ_DIV_SIGNED_EN
         neg_q <= 1'b0;
         neg_r <= 1'b0;
`endif
      end else if (accept) begin
         div_by_zero <= zero;
         if (zero) begin
            quotient <= '1;
            remainder <= dividend[DIVISOR_W-1:0];
         end else begin
            acc <= dvd_mag;
            dvs <= dvs_mag;
            prem <= '0;
            cnt <= CNT_W'(DIVIDEND_W);
`ifdef BM_SEQ_DIV_SIGNED_EN
            neg_q <= dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
            neg_r <= dividend[DIVIDEND_W-1];
`endif
         end
      end else if (state == RUN) begin
         acc <= acc_nxt;
         prem <= prem_nxt;
         cnt <= cnt - CNT_W'(1);
`ifndef BM_SEQ_DIV_SIGNED_EN
         if (last) begin
            quotient <= acc_nxt;
            remainder <= prem_nxt[DIVISOR_W-1:0];
         end
`endif
      end
`ifdef BM_SEQ_DIV_SIGNED_EN
      else if (state == FIX) begin
         quotient <= neg_q ? -acc : acc;
         remainder <= neg_r ? -prem[DIVISOR_W-1:0] : prem[DIVISOR_W-1:0];
      end
`endif
   end
endmodule

// File: tb/tb_bm_seq_div_str_arch.sv
// tb_bm_seq_div_str_arch: scoreboard bench for the sequential divider
module tb_bm_seq_div_str_arch;
   localparam int DW = 36;
   localparam int SW = 18;
`ifdef BM_SEQ_DIV_SIGNED_EN
   localparam int LAT = DW + 2;
`else
   localparam int LAT = DW + 1;
`endif
   logic clock = 1'b0, reset = 1'b1, start = 1'b0;
   logic [DW-1:0] dividend = '0, quotient;
   logic [SW-1:0] divisor = '0, remainder;
   logic busy, done, div_by_zero;
   int cyc = 0, pass_cnt = 0, total_cnt = 0;
   typedef struct {
      logic [DW-1:0] q;
      logic [SW-1:0] r;
      logic dz;
      int acc;
      int lat;
   } exp_t;
   exp_t sb[$];

   bm_seq_div_str_arch dut (
      .clock(clock), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
      .busy(busy), .done(done), .div_by_zero(div_by_zero), .quotient(quotient), .remainder(remainder)
   );

   initial forever #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   always @(negedge clock) begin
      if (done) begin
         if (sb.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_done: got done=1 expected done=0 at cycle %0d", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("quotient", 64'(quotient), 64'(e.q));
            chk("remainder", 64'(remainder), 64'(e.r));
            chk("div_by_zero", 64'(div_by_zero), 64'(e.dz));
            chk("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
         end
      end
   end

   task automatic issue(input logic [DW-1:0] a, input logic [SW-1:0] b, input logic [DW-1:0] q,
                        input logic [SW-1:0] r, input logic dz, input int lat, input bit push);
      exp_t e;
      start = 1'b1;
      dividend = a;
      divisor = b;
      @(posedge clock);
      #1;
      e.q = q; e.r = r; e.dz = dz; e.acc = cyc; e.lat = lat;
      if (push) sb.push_back(e);
      start = 1'b0;
   endtask

   task automatic wait_empty();
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         #1;
         if (sb.size() == 0) break;
      end
      if (sb.size() != 0) begin
         total_cnt++;
         $display("FAIL timeout: got %0d pending results expected 0", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      start = 1'b1;
      dividend = 36'd1000;
      divisor = 18'd7;
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_dz", 64'(div_by_zero), 64'd0);
      chk("reset_q", 64'(quotient), 64'd0);
      chk("reset_r", 64'(remainder), 64'd0);
      start = 1'b0;
      reset = 1'b0;
      @(negedge clock);
      issue(36'd1000, 18'd7, 36'd142, 18'd6, 1'b0, LAT, 1'b1);
      @(negedge clock);
      chk("run_busy", 64'(busy), 64'd1);
      wait_empty();
      chk("idle_busy", 64'(busy), 64'd0);
      @(negedge clock);
      issue(36'hF_FFFF_FFFF, 18'd1, 36'hF_FFFF_FFFF, 18'd0, 1'b0, LAT, 1'b1);
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         if (done) break;
      end
`ifdef BM_SEQ_DIV_SIGNED_EN
      issue(36'd5, 18'h3FFFF, -36'sd5, 18'd0, 1'b0, LAT, 1'b1);
`else
      issue(36'd5, 18'h3FFFF, 36'd0, 18'd5, 1'b0, LAT, 1'b1);
`endif
      wait_empty();
      @(negedge clock);
      issue(36'h0_0001_2345, 18'd0, 36'hF_FFFF_FFFF, 18'h12345, 1'b1, 1, 1'b1);
      wait_empty();
      @(negedge clock);
      issue(36'd100, 18'd3, 36'd33, 18'd1, 1'b0, LAT, 1'b1);
      repeat (9) @(negedge clock);
      start = 1'b1;
      dividend = 36'd9;
      divisor = 18'd9;
      chk("ignored_start_busy", 64'(busy), 64'd1);
      @(negedge clock);
      start = 1'b0;
      wait_empty();
      @(negedge clock);
      issue(36'd123456789, 18'd1000, 36'd123456, 18'd789, 1'b0, LAT, 1'b1);
      wait_empty();
      @(negedge clock);
      issue(36'h8_0000_0000, 18'h2_0000, 36'h4_0000, 18'd0, 1'b0, LAT, 1'b1);
      wait_empty();
      @(negedge clock);
`ifdef BM_SEQ_DIV_SIGNED_EN
      issue(36'h8_0000_0000, 18'h3FFFF, 36'h8_0000_0000, 18'd0, 1'b0, LAT, 1'b1);
      wait_empty();
      @(negedge clock);
      issue(-36'sd1000, 18'd7, -36'sd142, -18'sd6, 1'b0, LAT, 1'b1);
      wait_empty();
      @(negedge clock);
      issue(36'd1000, -18'sd7, -36'sd142, 18'd6, 1'b0, LAT, 1'b1);
      wait_empty();
      @(negedge clock);
`else
      issue(36'h8_0000_0000, 18'h3FFFF, 36'h2_0000, 18'h2_0000, 1'b0, LAT, 1'b1);
      wait_empty();
      @(negedge clock);
`endif
      issue(36'd100, 18'd3, 36'd0, 18'd0, 1'b0, LAT, 1'b0);
      repeat (19) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("midrun_reset_busy", 64'(busy), 64'd0);
      chk("midrun_reset_done", 64'(done), 64'd0);
      chk("midrun_reset_q", 64'(quotient), 64'd0);
      chk("midrun_reset_r", 64'(remainder), 64'd0);
      repeat (45) @(negedge clock);
      chk("midrun_reset_idle", 64'(busy), 64'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
